// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the pipelined RV32I control unit.
//   - RV32I major opcode constants
//   - ALU control, immediate-format and writeback-select encodings
//   - ctrl_t: the control word produced in D and carried into E
//   - alu_from_funct3: funct3 -> ALU operation for OP / OP-IMM
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef struct packed {
        logic        reg_write;
        result_src_t result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        alu_op_t     alu_ctrl;
        logic        alu_src_a;
        logic        alu_src_b;
        logic        pc_target_src;
        logic        illegal;
    } ctrl_t;

    // alt selects sub (funct3 000) or sra (funct3 101); callers decide
    // whether alt is meaningful for the opcode at hand.
    function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational D-stage instruction decode.
//   op, funct3, funct7_5 : instruction fields in D
//   ctrl                 : control word for the E/M/W pipeline
//   imm_src              : immediate format for the D-stage extender
// EXT_OPS=0 restricts the legal set to lw/sw/beq/addi/jal and R-type
// add/sub/slt/or/and. Illegal encodings yield an all-zero control word
// with only the illegal bit set.
module ctrl_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int EXT_OPS = 1
) (
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output ctrl_t      ctrl,
    output logic [2:0] imm_src
);

    localparam bit EXT = (EXT_OPS != 0);

    ctrl_t    c;
    imm_src_t imm;
    logic     legal;

    always_comb begin
        c     = '0;
        imm   = IMM_I;
        legal = 1'b0;
        case (op)
            OP_LOAD: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_MEM;
                c.alu_src_b  = 1'b1;
                c.alu_ctrl   = ALU_ADD;
                imm          = IMM_I;
                legal        = EXT ? (funct3 != 3'b011 && funct3[2:1] != 2'b11)
                                   : (funct3 == 3'b010);
            end
            OP_STORE: begin
                c.mem_write = 1'b1;
                c.alu_src_b = 1'b1;
                c.alu_ctrl  = ALU_ADD;
                imm         = IMM_S;
                legal       = EXT ? (funct3 <= 3'b010) : (funct3 == 3'b010);
            end
            OP_BRANCH: begin
                c.branch   = 1'b1;
                c.alu_ctrl = ALU_SUB;
                imm        = IMM_B;
                legal      = EXT ? (funct3[2:1] != 2'b01) : (funct3 == 3'b000);
            end
            OP_JAL: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_PC4;
                c.jump       = 1'b1;
                c.alu_ctrl   = ALU_ADD;
                imm          = IMM_J;
                legal        = 1'b1;
            end
            OP_JALR: begin
                c.reg_write     = 1'b1;
                c.result_src    = RES_PC4;
                c.jump          = 1'b1;
                c.pc_target_src = 1'b1;
                c.alu_src_b     = 1'b1;
                c.alu_ctrl      = ALU_ADD;
                imm             = IMM_I;
                legal           = EXT && (funct3 == 3'b000);
            end
            OP_IMM: begin
                c.reg_write = 1'b1;
                c.alu_src_b = 1'b1;
                // instr[30] is an immediate bit except for the shifts
                c.alu_ctrl  = alu_from_funct3(funct3, funct7_5 && funct3 == 3'b101);
                imm         = IMM_I;
                legal       = EXT ? !(funct3 == 3'b001 && funct7_5)
                                  : (funct3 == 3'b000);
            end
            OP_REG: begin
                c.reg_write = 1'b1;
                c.alu_ctrl  = alu_from_funct3(funct3, funct7_5);
                legal       = EXT ? (!funct7_5 || funct3 == 3'b000 || funct3 == 3'b101)
                                  : ((funct3 == 3'b000 || funct3 == 3'b010 ||
                                      funct3[2:1] == 2'b11) &&
                                     (!funct7_5 || funct3 == 3'b000));
            end
            OP_LUI: begin
                c.reg_write = 1'b1;
                c.alu_src_b = 1'b1;
                c.alu_ctrl  = ALU_PASSB;
                imm         = IMM_U;
                legal       = EXT;
            end
            OP_AUIPC: begin
                c.reg_write = 1'b1;
                c.alu_src_a = 1'b1;
                c.alu_src_b = 1'b1;
                c.alu_ctrl  = ALU_ADD;
                imm         = IMM_U;
                legal       = EXT;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            c   = '0;
            imm = IMM_I;
        end
        c.illegal = !legal;
    end

    assign ctrl    = c;
    assign imm_src = imm;

endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: RV32I control path for a 5-stage pipeline.
// Decodes in D (ctrl_decoder) and carries control through E, M and W.
//   clk, reset                        : clock, synchronous active-high reset
//   op_d, funct3_d, funct7_5_d        : instruction fields in D
//   flush_e                           : replace the instruction entering E by a bubble
//   zero_e, neg_e, carry_e, ovf_e     : ALU flags of A-B in E
//   imm_src_d, illegal_d              : D-stage decode outputs
//   alu_src_a_e .. result_src_e0      : E-stage controls
//   mem_write_m, reg_write_m, funct3_m: M-stage controls
//   reg_write_w, result_src_w         : W-stage controls
//   illegal_seen                      : sticky, set once an illegal instr reaches W
// ALU_CTRL_W must be at least 4; extra high bits read as zero.
module pipelined_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int EXT_OPS    = 1,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            op_d,
    input  logic [2:0]            funct3_d,
    input  logic                  funct7_5_d,
    input  logic                  flush_e,
    input  logic                  zero_e,
    input  logic                  neg_e,
    input  logic                  carry_e,
    input  logic                  ovf_e,
    output logic [2:0]            imm_src_d,
    output logic                  illegal_d,
    output logic                  alu_src_a_e,
    output logic                  alu_src_b_e,
    output logic [ALU_CTRL_W-1:0] alu_control_e,
    output logic                  pc_src_e,
    output logic                  pc_target_src_e,
    output logic                  result_src_e0,
    output logic                  mem_write_m,
    output logic                  reg_write_m,
    output logic [2:0]            funct3_m,
    output logic                  reg_write_w,
    output logic [1:0]            result_src_w,
    output logic                  illegal_seen
);

    ctrl_t       ctrl_d;
    ctrl_t       ctrl_e;
    logic [2:0]  funct3_e;
    result_src_t result_src_m;
    logic        illegal_m;
    logic        taken;

    ctrl_decoder #(.EXT_OPS(EXT_OPS)) u_dec (
        .op       (op_d),
        .funct3   (funct3_d),
        .funct7_5 (funct7_5_d),
        .ctrl     (ctrl_d),
        .imm_src  (imm_src_d)
    );

    assign illegal_d = ctrl_d.illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_e       <= '0;
            funct3_e     <= '0;
            reg_write_m  <= 1'b0;
            result_src_m <= RES_ALU;
            mem_write_m  <= 1'b0;
            funct3_m     <= '0;
            illegal_m    <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= '0;
            illegal_seen <= 1'b0;
        end else begin
            if (flush_e) begin
                ctrl_e   <= '0;
                funct3_e <= '0;
            end else begin
                ctrl_e   <= ctrl_d;
                funct3_e <= funct3_d;
            end
            reg_write_m  <= ctrl_e.reg_write;
            result_src_m <= ctrl_e.result_src;
            mem_write_m  <= ctrl_e.mem_write;
            funct3_m     <= funct3_e;
            illegal_m    <= ctrl_e.illegal;
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
            // set on the edge the illegal instruction moves M -> W
            illegal_seen <= illegal_seen | illegal_m;
        end
    end

    // Branch condition from the flags of A-B: lt = neg^ovf, ltu = !carry.
    always_comb begin
        taken = 1'b0;
        case (funct3_e)
            3'b000:  taken = zero_e;
            3'b001:  taken = !zero_e;
            3'b100:  taken = neg_e ^ ovf_e;
            3'b101:  taken = !(neg_e ^ ovf_e);
            3'b110:  taken = !carry_e;
            3'b111:  taken = carry_e;
            default: taken = 1'b0;
        endcase
    end

    assign pc_src_e        = ctrl_e.jump | (ctrl_e.branch & taken);
    assign pc_target_src_e = ctrl_e.pc_target_src;
    assign alu_src_a_e     = ctrl_e.alu_src_a;
    assign alu_src_b_e     = ctrl_e.alu_src_b;
    assign alu_control_e   = ALU_CTRL_W'(ctrl_e.alu_ctrl);
    assign result_src_e0   = (ctrl_e.result_src == RES_MEM);

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed scenarios followed by random
// instructions, all checked against an instruction-level reference model
// that tracks what each pipeline stage should hold.
module tb_pipelined_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op_d;
    logic [2:0] funct3_d;
    logic       funct7_5_d;
    logic       flush_e;
    logic       zero_e, neg_e, carry_e, ovf_e;

    logic [2:0] imm_src_d;
    logic       illegal_d;
    logic       alu_src_a_e, alu_src_b_e;
    logic [3:0] alu_control_e;
    logic       pc_src_e, pc_target_src_e, result_src_e0;
    logic       mem_write_m, reg_write_m;
    logic [2:0] funct3_m;
    logic       reg_write_w;
    logic [1:0] result_src_w;
    logic       illegal_seen;

    // base-ISA instance: only illegal_d is examined
    logic [2:0] b_imm_src_d;
    logic       b_illegal_d, b_alu_src_a_e, b_alu_src_b_e;
    logic [3:0] b_alu_control_e;
    logic       b_pc_src_e, b_pc_target_src_e, b_result_src_e0;
    logic       b_mem_write_m, b_reg_write_m;
    logic [2:0] b_funct3_m;
    logic       b_reg_write_w;
    logic [1:0] b_result_src_w;
    logic       b_illegal_seen;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_control_unit #(.EXT_OPS(1), .ALU_CTRL_W(4)) dut (
        .clk(clk), .reset(reset), .op_d(op_d), .funct3_d(funct3_d),
        .funct7_5_d(funct7_5_d), .flush_e(flush_e),
        .zero_e(zero_e), .neg_e(neg_e), .carry_e(carry_e), .ovf_e(ovf_e),
        .imm_src_d(imm_src_d), .illegal_d(illegal_d),
        .alu_src_a_e(alu_src_a_e), .alu_src_b_e(alu_src_b_e),
        .alu_control_e(alu_control_e), .pc_src_e(pc_src_e),
        .pc_target_src_e(pc_target_src_e), .result_src_e0(result_src_e0),
        .mem_write_m(mem_write_m), .reg_write_m(reg_write_m),
        .funct3_m(funct3_m), .reg_write_w(reg_write_w),
        .result_src_w(result_src_w), .illegal_seen(illegal_seen)
    );

    pipelined_control_unit #(.EXT_OPS(0), .ALU_CTRL_W(4)) dut_base (
        .clk(clk), .reset(reset), .op_d(op_d), .funct3_d(funct3_d),
        .funct7_5_d(funct7_5_d), .flush_e(flush_e),
        .zero_e(zero_e), .neg_e(neg_e), .carry_e(carry_e), .ovf_e(ovf_e),
        .imm_src_d(b_imm_src_d), .illegal_d(b_illegal_d),
        .alu_src_a_e(b_alu_src_a_e), .alu_src_b_e(b_alu_src_b_e),
        .alu_control_e(b_alu_control_e), .pc_src_e(b_pc_src_e),
        .pc_target_src_e(b_pc_target_src_e), .result_src_e0(b_result_src_e0),
        .mem_write_m(b_mem_write_m), .reg_write_m(b_reg_write_m),
        .funct3_m(b_funct3_m), .reg_write_w(b_reg_write_w),
        .result_src_w(b_result_src_w), .illegal_seen(b_illegal_seen)
    );

    // Expected control of one instruction. alu_k=0 means the ALU code is
    // unconstrained (jal); for ill=1 only writes/branch/jump are constrained.
    typedef struct packed {
        bit       rw;
        bit [1:0] rs;
        bit       mw;
        bit       jump;
        bit       br;
        bit [3:0] alu;
        bit       alu_k;
        bit       sa;
        bit       sb;
        bit       tgt;
        bit [2:0] imm;
        bit [2:0] f3;
        bit       ill;
    } exp_t;

    exp_t st_e, st_m, st_w;
    bit   seen;

    function automatic exp_t bubble();
        exp_t e = '0;
        e.alu_k = 1'b1;
        return e;
    endfunction

    function automatic bit [3:0] alu_of(input bit [2:0] f3, input bit alt);
        case (f3)
            3'd0: return alt ? 4'd1 : 4'd0;  // sub / add
            3'd1: return 4'd7;               // sll
            3'd2: return 4'd5;               // slt
            3'd3: return 4'd6;               // sltu
            3'd4: return 4'd4;               // xor
            3'd5: return alt ? 4'd9 : 4'd8;  // sra / srl
            3'd6: return 4'd3;               // or
            default: return 4'd2;            // and
        endcase
    endfunction

    function automatic exp_t ref_dec(input bit ext, input bit [6:0] op,
                                     input bit [2:0] f3, input bit f7);
        exp_t e = '0;
        bit   ok = 1'b0;
        e.alu_k = 1'b1;
        e.f3    = f3;
        case (op)
            7'b0000011: begin  // loads lb lh lw lbu lhu
                e.rw = 1; e.rs = 2'b01; e.sb = 1; e.alu = 4'd0; e.imm = 3'd0;
                ok = ext ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 == 2);
            end
            7'b0100011: begin  // stores sb sh sw
                e.mw = 1; e.sb = 1; e.alu = 4'd0; e.imm = 3'd1;
                ok = ext ? (f3 <= 2) : (f3 == 2);
            end
            7'b1100011: begin  // branches
                e.br = 1; e.alu = 4'd1; e.imm = 3'd2;
                ok = ext ? (f3 != 2 && f3 != 3) : (f3 == 0);
            end
            7'b1101111: begin  // jal
                e.rw = 1; e.rs = 2'b10; e.jump = 1; e.imm = 3'd3; e.alu_k = 0;
                ok = 1;
            end
            7'b1100111: begin  // jalr
                e.rw = 1; e.rs = 2'b10; e.jump = 1; e.tgt = 1; e.sb = 1;
                e.alu = 4'd0; e.imm = 3'd0;
                ok = ext && f3 == 0;
            end
            7'b0010011: begin  // OP-IMM
                e.rw = 1; e.sb = 1; e.imm = 3'd0;
                e.alu = alu_of(f3, f3 == 5 && f7);
                ok = ext ? !(f3 == 1 && f7) : (f3 == 0);
            end
            7'b0110011: begin  // OP
                e.rw = 1; e.alu = alu_of(f3, f7);
                ok = ext ? (!f7 || f3 == 0 || f3 == 5)
                         : ((f3 == 0 && 1) || (!f7 && (f3 == 2 || f3 == 6 || f3 == 7)));
            end
            7'b0110111: begin  // lui
                e.rw = 1; e.sb = 1; e.alu = 4'd10; e.imm = 3'd4; ok = ext;
            end
            7'b0010111: begin  // auipc
                e.rw = 1; e.sa = 1; e.sb = 1; e.alu = 4'd0; e.imm = 3'd4; ok = ext;
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            e.rw = 0; e.mw = 0; e.br = 0; e.jump = 0; e.ill = 1;
        end
        return e;
    endfunction

    function automatic bit ref_taken(input bit [2:0] f3);
        bit lt  = (neg_e != ovf_e);
        bit ltu = !carry_e;
        case (f3)
            3'd0: return zero_e;
            3'd1: return !zero_e;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive D inputs and E flags, check every stage, then advance the model.
    task automatic step(input bit [6:0] op, input bit [2:0] f3, input bit f7,
                        input bit [3:0] flg, input bit fl, input bit rs);
        exp_t d, db;
        @(negedge clk);
        op_d = op; funct3_d = f3; funct7_5_d = f7;
        {zero_e, neg_e, carry_e, ovf_e} = flg;
        flush_e = fl; reset = rs;
        d  = ref_dec(1'b1, op, f3, f7);
        db = ref_dec(1'b0, op, f3, f7);
        #1;
        chk("illegal_d", illegal_d, d.ill);
        if (!d.ill) chk("imm_src_d", imm_src_d, d.imm);
        chk("illegal_d_base", b_illegal_d, db.ill);
        chk("pc_src_e", pc_src_e, st_e.jump | (st_e.br & ref_taken(st_e.f3)));
        if (!st_e.ill) begin
            chk("alu_src_a_e", alu_src_a_e, st_e.sa);
            chk("alu_src_b_e", alu_src_b_e, st_e.sb);
            chk("pc_target_src_e", pc_target_src_e, st_e.tgt);
            chk("result_src_e0", result_src_e0, st_e.rs == 2'b01);
            if (st_e.alu_k) chk("alu_control_e", alu_control_e, st_e.alu);
        end
        chk("mem_write_m", mem_write_m, st_m.mw);
        chk("reg_write_m", reg_write_m, st_m.rw);
        chk("funct3_m", funct3_m, st_m.f3);
        chk("reg_write_w", reg_write_w, st_w.rw);
        if (!st_w.ill) chk("result_src_w", result_src_w, st_w.rs);
        chk("illegal_seen", illegal_seen, seen);
        @(posedge clk);
        if (rs) begin
            st_e = bubble(); st_m = bubble(); st_w = bubble(); seen = 0;
        end else begin
            seen = seen | st_m.ill;
            st_w = st_m;
            st_m = st_e;
            st_e = fl ? bubble() : d;
        end
    endtask

    bit [6:0] ops [10] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
                           7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111, 7'b1111111};

    initial begin
        bit [6:0] rop;
        reset = 1; flush_e = 0; op_d = 0; funct3_d = 0; funct7_5_d = 0;
        {zero_e, neg_e, carry_e, ovf_e} = 4'b0;
        repeat (2) @(posedge clk);
        st_e = bubble(); st_m = bubble(); st_w = bubble(); seen = 0;

        // add, then bltu with carry clear (taken) and set (not taken)
        step(7'b0110011, 3'd0, 0, 4'b0000, 0, 0);
        step(7'b1100011, 3'd6, 0, 4'b0000, 0, 0);
        step(7'b0010011, 3'd0, 0, 4'b0000, 0, 0);
        step(7'b1100011, 3'd6, 0, 4'b0000, 0, 0);
        step(7'b0010011, 3'd0, 0, 4'b0010, 0, 0);
        // lw with flush in the same cycle
        step(7'b0000011, 3'd2, 0, 4'b0000, 1, 0);
        step(7'b0010011, 3'd0, 0, 4'b0000, 0, 0);
        // illegal opcode followed by enough nops to reach W
        step(7'b1111111, 3'd0, 0, 4'b0000, 0, 0);
        repeat (4) step(7'b0010011, 3'd0, 0, 4'b0000, 0, 0);
        // jalr, then sw interrupted by reset while in E
        step(7'b1100111, 3'd0, 0, 4'b0000, 0, 0);
        step(7'b0100011, 3'd2, 0, 4'b0000, 0, 0);
        step(7'b0010011, 3'd0, 0, 4'b0000, 0, 1);
        step(7'b0010011, 3'd0, 0, 4'b0000, 0, 0);
        // xori: legal for the full set, illegal for the base set
        step(7'b0010011, 3'd4, 0, 4'b0000, 0, 0);
        // reset and flush together: reset wins
        step(7'b0000011, 3'd2, 0, 4'b0000, 1, 1);

        for (int i = 0; i < 500; i++) begin
            rop = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            step(rop, 3'($urandom), 1'($urandom), 4'($urandom),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
